// File: rtl/prbs_ber_checker_pkg.sv
// Shared definitions for the PRBS generator and BER checker.
// Holds the PRBS9 tap defaults (x^9 + x^5 + 1) and the checker FSM encoding,
// so transmit and receive sides agree on the recurrence.
package prbs_ber_checker_pkg;

  localparam int PRBS_NB_DEF         = 9;
  localparam int PRBS_LOW_ORDER_DEF  = 5;
  localparam int PRBS_HIGH_ORDER_DEF = 9;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_e;

endpackage

// File: rtl/prbs_ber_checker_sat.sv
// sat_counter: saturating up-counter with synchronous clear.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clr_i          : zero the count (wins over inc_i)
//   inc_i          : increment by one, holding at all-ones
//   count_o        : current count
//   sat_o          : count is at, or is reaching on this edge, all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         sat_o
);

  localparam logic [W-1:0] MAX    = '1;
  localparam logic [W-1:0] MAX_M1 = MAX - W'(1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)                      count_d = '0;
    else if (inc_i && count_q != MAX) count_d = count_q + W'(1);
  end

  // Flag goes high on the same edge the count lands on all-ones, so the
  // sticky bit in the parent lines up with the counter value.
  assign sat_o   = !clr_i && ((count_q == MAX) || (inc_i && count_q == MAX_M1));
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/prbs_ber_checker.sv
// prbs_ber_checker: locks a local LFSR onto a received PRBS bit stream and
// counts bit errors while locked.
// Ports:
//   clock, in_reset      : clock, synchronous active-high reset
//   in_enable, in_data   : received bit strobe and value (slicer sign)
//   in_clear             : zero counters and the saturation flag
//   out_lock             : registered LOCKED indicator
//   out_bit_count        : bits checked while locked
//   out_err_count        : errored bits while locked
//   out_lock_loss_count  : number of LOCKED -> LOAD drops
//   out_count_sat        : sticky, some counter hit all-ones
module prbs_ber_checker
  import prbs_ber_checker_pkg::*;
#(
  parameter int NB_PRBS         = PRBS_NB_DEF,
  parameter int PRBS_LOW_ORDER  = PRBS_LOW_ORDER_DEF,
  parameter int PRBS_HIGH_ORDER = PRBS_HIGH_ORDER_DEF,
  parameter int SYNC_LEN        = 32,
  parameter int WINDOW_LEN      = 128,
  parameter int LOSS_THRESHOLD  = 16,
  parameter int NB_COUNT        = 32
) (
  input  logic                clock,
  input  logic                in_reset,
  input  logic                in_enable,
  input  logic                in_data,
  input  logic                in_clear,
  output logic                out_lock,
  output logic [NB_COUNT-1:0] out_bit_count,
  output logic [NB_COUNT-1:0] out_err_count,
  output logic [7:0]          out_lock_loss_count,
  output logic                out_count_sat
);

  localparam int LW = $clog2(NB_PRBS + 1);
  localparam int SW = $clog2(SYNC_LEN + 1);
  localparam int WW = $clog2(WINDOW_LEN + 1);
  localparam int EW = $clog2(LOSS_THRESHOLD + 1);

  prbs_state_e        state_q, state_d;
  logic [NB_PRBS-1:0] sr_q, sr_d;
  logic [LW-1:0]      load_q, load_d;
  logic [SW-1:0]      sync_q, sync_d;
  logic [WW-1:0]      win_q, win_d;
  logic [EW-1:0]      werr_q, werr_d, werr_inc;
  logic               lock_q, sat_q;
  logic               pred, mism, lost;
  logic               bit_inc, err_inc;
  logic               bit_sat, err_sat, loss_sat;

  assign pred = sr_q[PRBS_HIGH_ORDER-1] ^ sr_q[PRBS_LOW_ORDER-1];
  assign mism = pred ^ in_data;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    load_d   = load_q;
    sync_d   = sync_q;
    win_d    = win_q;
    werr_d   = werr_q;
    werr_inc = werr_q + EW'(mism);
    lost     = 1'b0;
    if (in_enable) begin
      case (state_q)
        ST_LOAD: begin
          sr_d = {sr_q[NB_PRBS-2:0], in_data};
          if (load_q == LW'(NB_PRBS - 1)) begin
            load_d = '0;
            // All-zero is the LFSR lock-up state; reload instead of syncing.
            if (sr_d != '0) begin
              state_d = ST_SYNC;
              sync_d  = '0;
            end
          end else begin
            load_d = load_q + LW'(1);
          end
        end
        ST_SYNC: begin
          sr_d = {sr_q[NB_PRBS-2:0], pred};
          if (mism) begin
            state_d = ST_LOAD;
            load_d  = '0;
          end else if (sync_q == SW'(SYNC_LEN - 1)) begin
            state_d = ST_LOCKED;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            sync_d = sync_q + SW'(1);
          end
        end
        ST_LOCKED: begin
          // Flywheel on the local prediction so errors don't corrupt sr.
          sr_d = {sr_q[NB_PRBS-2:0], pred};
          if (werr_inc == EW'(LOSS_THRESHOLD)) begin
            state_d = ST_LOAD;
            load_d  = '0;
            lost    = 1'b1;
          end else if (win_q == WW'(WINDOW_LEN - 1)) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + WW'(1);
            werr_d = werr_inc;
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (in_reset) begin
      state_q <= ST_LOAD;
      sr_q    <= '0;
      load_q  <= '0;
      sync_q  <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      lock_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      load_q  <= load_d;
      sync_q  <= sync_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      // Follows the state one cycle behind.
      lock_q  <= (state_q == ST_LOCKED);
      sat_q   <= in_clear ? 1'b0 : (sat_q | bit_sat | err_sat | loss_sat);
    end
  end

  assign bit_inc = in_enable && (state_q == ST_LOCKED);
  assign err_inc = bit_inc && mism;

  sat_counter #(.W(NB_COUNT)) u_bit_cnt (
    .clk_i(clock), .rst_i(in_reset), .clr_i(in_clear), .inc_i(bit_inc),
    .count_o(out_bit_count), .sat_o(bit_sat)
  );

  sat_counter #(.W(NB_COUNT)) u_err_cnt (
    .clk_i(clock), .rst_i(in_reset), .clr_i(in_clear), .inc_i(err_inc),
    .count_o(out_err_count), .sat_o(err_sat)
  );

  sat_counter #(.W(8)) u_loss_cnt (
    .clk_i(clock), .rst_i(in_reset), .clr_i(in_clear), .inc_i(lost),
    .count_o(out_lock_loss_count), .sat_o(loss_sat)
  );

  assign out_lock      = lock_q;
  assign out_count_sat = sat_q;

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Self-checking bench for prbs_ber_checker. A PRBS9 source feeds two
// instances (32-bit and 4-bit counters); each scenario pushes the expected
// outputs for every driven bit and compares them after the clock edge.
module tb_prbs_ber_checker;

  logic        clock = 1'b0;
  logic        in_reset, in_enable, in_data, in_clear;
  logic        out_lock, out_count_sat;
  logic [31:0] out_bit_count, out_err_count;
  logic [7:0]  out_lock_loss_count;
  logic        lock4, sat4;
  logic [3:0]  bc4, ec4;
  logic [7:0]  llc4;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        lock;
    logic [31:0] bc;
    logic [31:0] ec;
    logic [7:0]  llc;
    logic        sat;
  } exp_t;

  exp_t exp_q[$];
  logic [8:0] gen_sr = 9'h1FF;

  always #5 clock = ~clock;

  prbs_ber_checker dut (
    .clock(clock), .in_reset(in_reset), .in_enable(in_enable),
    .in_data(in_data), .in_clear(in_clear), .out_lock(out_lock),
    .out_bit_count(out_bit_count), .out_err_count(out_err_count),
    .out_lock_loss_count(out_lock_loss_count), .out_count_sat(out_count_sat)
  );

  prbs_ber_checker #(.NB_COUNT(4)) dut4 (
    .clock(clock), .in_reset(in_reset), .in_enable(in_enable),
    .in_data(in_data), .in_clear(in_clear), .out_lock(lock4),
    .out_bit_count(bc4), .out_err_count(ec4),
    .out_lock_loss_count(llc4), .out_count_sat(sat4)
  );

  // Reference transmitter: x^9 + x^5 + 1.
  task automatic next_bit(output logic b);
    b      = gen_sr[8] ^ gen_sr[4];
    gen_sr = {gen_sr[7:0], b};
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    in_reset = 1'b1; in_enable = 1'b0; in_data = 1'b0; in_clear = 1'b0;
    tick(); tick();
    in_reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    in_reset = 1'b1; in_enable = 1'b1; in_data = 1'b1; in_clear = 1'b0;
    tick();
    e = '{lock: 1'b0, bc: 32'd0, ec: 32'd0, llc: 8'd0, sat: 1'b0};
    exp_q.push_back(e);
    tick();
    e = exp_q.pop_front();
    n_checks++;
    if ({out_lock, out_bit_count, out_err_count, out_lock_loss_count, out_count_sat} !==
        {e.lock, e.bc, e.ec, e.llc, e.sat}) begin
      n_fail++;
      $display("FAIL reset: got lock=%0b bits=%0d errs=%0d loss=%0d sat=%0b, expected all zero",
               out_lock, out_bit_count, out_err_count, out_lock_loss_count, out_count_sat);
    end
    n_checks++;
    if ({lock4, bc4, ec4, llc4, sat4} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset4: got lock=%0b bits=%0d errs=%0d loss=%0d sat=%0b, expected all zero",
               lock4, bc4, ec4, llc4, sat4);
    end
    in_reset = 1'b0;
  endtask

  task automatic test_lock_acq();
    exp_t e;
    logic b;
    do_reset();
    for (int n = 1; n <= 1000; n++) begin
      next_bit(b);
      in_enable = 1'b1; in_data = b;
      e.lock = (n >= 42);
      e.bc   = (n >= 42) ? 32'(n - 41) : 32'd0;
      e.ec   = 32'd0; e.llc = 8'd0; e.sat = 1'b0;
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({out_lock, out_bit_count, out_err_count, out_lock_loss_count, out_count_sat} !==
          {e.lock, e.bc, e.ec, e.llc, e.sat}) begin
        n_fail++;
        $display("FAIL lock_acq n=%0d: got lock=%0b bits=%0d errs=%0d loss=%0d, expected lock=%0b bits=%0d errs=%0d loss=%0d",
                 n, out_lock, out_bit_count, out_err_count, out_lock_loss_count,
                 e.lock, e.bc, e.ec, e.llc);
      end
    end
  endtask

  task automatic test_single_error();
    exp_t e;
    logic b;
    int   reps;
    do_reset();
    for (int n = 1; n <= 90; n++) begin
      next_bit(b);
      // After bit 70, hold in_enable low for a few cycles: nothing may move.
      reps = (n == 70) ? 6 : 1;
      for (int r = 0; r < reps; r++) begin
        in_enable = (r == 0);
        in_data   = (n == 61) ? ~b : b;
        e.lock = (n >= 42);
        e.bc   = (n >= 42) ? 32'(n - 41) : 32'd0;
        e.ec   = (n >= 61) ? 32'd1 : 32'd0;
        e.llc  = 8'd0; e.sat = 1'b0;
        exp_q.push_back(e);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if ({out_lock, out_bit_count, out_err_count, out_lock_loss_count, out_count_sat} !==
            {e.lock, e.bc, e.ec, e.llc, e.sat}) begin
          n_fail++;
          $display("FAIL single_err n=%0d r=%0d: got lock=%0b bits=%0d errs=%0d, expected lock=%0b bits=%0d errs=%0d",
                   n, r, out_lock, out_bit_count, out_err_count, e.lock, e.bc, e.ec);
        end
      end
    end
  endtask

  task automatic test_loss_of_lock();
    exp_t e;
    logic b;
    do_reset();
    for (int n = 1; n <= 150; n++) begin
      next_bit(b);
      in_enable = 1'b1;
      in_data   = (n >= 61 && n <= 76) ? ~b : b;
      e.lock = (n >= 42 && n <= 76) || (n >= 118);
      if (n < 42)       e.bc = 32'd0;
      else if (n <= 76) e.bc = 32'(n - 41);
      else if (n < 118) e.bc = 32'd35;
      else              e.bc = 32'(35 + n - 117);
      if (n <= 60)      e.ec = 32'd0;
      else if (n <= 76) e.ec = 32'(n - 60);
      else              e.ec = 32'd16;
      e.llc = (n >= 76) ? 8'd1 : 8'd0;
      e.sat = 1'b0;
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({out_lock, out_bit_count, out_err_count, out_lock_loss_count, out_count_sat} !==
          {e.lock, e.bc, e.ec, e.llc, e.sat}) begin
        n_fail++;
        $display("FAIL loss_of_lock n=%0d: got lock=%0b bits=%0d errs=%0d loss=%0d, expected lock=%0b bits=%0d errs=%0d loss=%0d",
                 n, out_lock, out_bit_count, out_err_count, out_lock_loss_count,
                 e.lock, e.bc, e.ec, e.llc);
      end
    end
  endtask

  task automatic test_all_zero();
    exp_t e;
    do_reset();
    for (int n = 1; n <= 500; n++) begin
      in_enable = 1'b1; in_data = 1'b0;
      e = '{lock: 1'b0, bc: 32'd0, ec: 32'd0, llc: 8'd0, sat: 1'b0};
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({out_lock, out_bit_count, out_err_count, out_lock_loss_count, out_count_sat} !==
          {e.lock, e.bc, e.ec, e.llc, e.sat}) begin
        n_fail++;
        $display("FAIL all_zero n=%0d: got lock=%0b bits=%0d errs=%0d loss=%0d sat=%0b, expected all zero",
                 n, out_lock, out_bit_count, out_err_count, out_lock_loss_count, out_count_sat);
      end
    end
  endtask

  task automatic test_clear_priority();
    exp_t e;
    logic b;
    do_reset();
    for (int n = 1; n <= 80; n++) begin
      next_bit(b);
      in_enable = 1'b1;
      in_data   = (n == 61) ? ~b : b;
      in_clear  = (n == 61);
      e.lock = (n >= 42);
      if (n < 42)       e.bc = 32'd0;
      else if (n <= 60) e.bc = 32'(n - 41);
      else              e.bc = 32'(n - 61);
      e.ec = 32'd0; e.llc = 8'd0; e.sat = 1'b0;
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({out_lock, out_bit_count, out_err_count, out_lock_loss_count, out_count_sat} !==
          {e.lock, e.bc, e.ec, e.llc, e.sat}) begin
        n_fail++;
        $display("FAIL clear_prio n=%0d: got lock=%0b bits=%0d errs=%0d, expected lock=%0b bits=%0d errs=%0d",
                 n, out_lock, out_bit_count, out_err_count, e.lock, e.bc, e.ec);
      end
    end
    in_clear = 1'b0;
  endtask

  task automatic test_midlock_reset();
    exp_t e;
    logic b;
    do_reset();
    for (int n = 1; n <= 60; n++) begin
      next_bit(b);
      in_enable = 1'b1; in_data = b;
      tick();
    end
    n_checks++;
    if (out_lock !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_prelock: got lock=%0b, expected 1", out_lock);
    end
    // Reset with a live enabled bit; it must still win.
    next_bit(b);
    in_reset = 1'b1; in_enable = 1'b1; in_data = b;
    e = '{lock: 1'b0, bc: 32'd0, ec: 32'd0, llc: 8'd0, sat: 1'b0};
    exp_q.push_back(e);
    tick();
    in_reset = 1'b0;
    for (int m = 0; m <= 50; m++) begin
      if (m > 0) begin
        next_bit(b);
        in_data = b;
        e.lock = (m >= 42);
        e.bc   = (m >= 42) ? 32'(m - 41) : 32'd0;
        e.ec   = 32'd0; e.llc = 8'd0; e.sat = 1'b0;
        exp_q.push_back(e);
        tick();
      end
      e = exp_q.pop_front();
      n_checks++;
      if ({out_lock, out_bit_count, out_err_count, out_lock_loss_count, out_count_sat} !==
          {e.lock, e.bc, e.ec, e.llc, e.sat}) begin
        n_fail++;
        $display("FAIL midreset m=%0d: got lock=%0b bits=%0d errs=%0d, expected lock=%0b bits=%0d errs=%0d",
                 m, out_lock, out_bit_count, out_err_count, e.lock, e.bc, e.ec);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic b;
    do_reset();
    for (int n = 1; n <= 70; n++) begin
      next_bit(b);
      in_enable = 1'b1; in_data = b;
      in_clear  = (n == 62);
      e.lock = (n >= 42);
      if (n < 42)       e.bc = 32'd0;
      else if (n < 62)  e.bc = (n - 41 > 15) ? 32'd15 : 32'(n - 41);
      else              e.bc = 32'(n - 62);
      e.ec  = 32'd0; e.llc = 8'd0;
      e.sat = (n >= 56 && n < 62);
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({lock4, bc4, ec4, llc4, sat4} !== {e.lock, e.bc[3:0], e.ec[3:0], e.llc, e.sat}) begin
        n_fail++;
        $display("FAIL saturation n=%0d: got lock=%0b bits=%0d errs=%0d sat=%0b, expected lock=%0b bits=%0d errs=%0d sat=%0b",
                 n, lock4, bc4, ec4, sat4, e.lock, e.bc, e.ec, e.sat);
      end
    end
    in_clear = 1'b0;
  endtask

  initial begin
    in_reset = 1'b1; in_enable = 1'b0; in_data = 1'b0; in_clear = 1'b0;
    test_reset();
    test_lock_acq();
    test_single_error();
    test_loss_of_lock();
    test_all_zero();
    test_clear_priority();
    test_midlock_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
